// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch path.
//   XLEN          - architectural register / address width
//   NOP_INSTR     - canonical RV32I no-op (addi x0, x0, 0)
//   INSTR_BYTES   - PC stride between sequential instructions
//   fetch_entry_t - one fetched instruction together with its PC
//   align_word    - clears the two low address bits (word alignment)
package riscv_pkg;

  localparam int unsigned      XLEN        = 32;
  localparam logic [XLEN-1:0]  NOP_INSTR   = 32'h0000_0013;
  localparam logic [XLEN-1:0]  INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched {pc, instr} pairs between fetch and decode.
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset; clears pointers, count and entries
//   flush_i      - empties the queue (pointers and count to zero); loses to rst
//   push_i       - write push_pc_i/push_instr_i at the tail (accepted if not full or popping)
//   push_pc_i    - PC of the entry being pushed
//   push_instr_i - instruction of the entry being pushed
//   pop_i        - advance the head (ignored when empty)
//   full_o       - count equals DEPTH
//   valid_o      - count is non-zero
//   head_pc_o    - PC of the head entry
//   head_instr_o - instruction of the head entry
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic [XLEN-1:0] push_instr_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            valid_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t        entries_q [DEPTH];
  fetch_entry_t        entries_d [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q,  count_d;
  logic                do_push, do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o       = (count_q == CntW'(DEPTH));
  assign valid_o      = (count_q != '0);
  assign head_pc_o    = entries_q[rd_ptr_q].pc;
  assign head_instr_o = entries_q[rd_ptr_q].instr;

  assign do_pop  = pop_i && valid_o;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        entries_d[wr_ptr_q] = '{pc: push_pc_i, instr: push_instr_i};
        wr_ptr_d            = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Reset contents make the head read back as {0, NOP} out of reset.
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '{pc: '0, instr: NOP_INSTR};
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory and
// buffers fetched instructions in a small queue in front of decode.
//   clk            - clock, rising edge
//   rst            - synchronous active-high reset (PC to RESET_PC, queue emptied)
//   imem_addr      - byte address presented to instruction memory (the PC)
//   imem_instr     - instruction word at imem_addr, valid in the same cycle
//   redirect_valid - branch/jump redirect; flushes the queue and reloads the PC
//   redirect_pc    - redirect target (low two bits ignored)
//   out_valid      - queue head holds a fetched instruction
//   out_ready      - decode accepts the head this cycle
//   out_pc         - PC of the head entry
//   out_instr      - instruction of the head entry
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            q_full;
  logic            q_valid;
  logic            pop;
  logic            push;

  assign imem_addr = pc_q;
  assign out_valid = q_valid;

  // A redirect squashes both the handshake and the fetch of this cycle; decode is
  // responsible for discarding whatever it saw at the head.
  assign pop  = q_valid && out_ready && !redirect_valid;
  assign push = !redirect_valid && (!q_full || pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + INSTR_BYTES;  // wraps modulo 2^32
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_pc_i    (pc_q),
    .push_instr_i (imem_instr),
    .pop_i        (pop),
    .full_o       (q_full),
    .valid_o      (q_valid),
    .head_pc_o    (out_pc),
    .head_instr_o (out_instr)
  );

endmodule
